// File: rtl/p_divider.sv
// p_divider: iterative radix-2 restoring unsigned divider.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
// A quotient too wide for WIDTH bits (including divide-by-zero) is flagged at the accept edge
// and finishes in a single cycle.
module p_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [2*WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               busy,
    output logic               ready,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic [WIDTH-1:0] dividendHigh;
    logic [WIDTH-1:0] dividendLow;
    logic             inputOverflow;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trialDiff;
    logic             trialFits;
    logic [WIDTH:0]   rStep;
    logic [WIDTH:0]   qWide;
    logic [WIDTH-1:0] qStep;

    // Accept decode, overflow pre-check and one restoring-division trial step
    always_comb begin
        accept        = (state_q == IDLE) && enable;
        dividendHigh  = dataa[2*WIDTH-1:WIDTH];
        dividendLow   = dataa[WIDTH-1:0];
        inputOverflow = (dividendHigh >= datab);
        trial         = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trialFits     = (trial >= {1'b0, divisor_q});
        trialDiff     = trial - {1'b0, divisor_q};
        rStep         = trialFits ? trialDiff : trial;
        qWide         = {q_q, trialFits};
        qStep         = qWide[WIDTH-1:0];
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: overflowing requests skip straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = inputOverflow ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; visible results only change on entry to DONE
    always_comb begin
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        r_d        = r_q;
        q_d        = q_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        overflow_d = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    divisor_d = datab;
                    r_d       = {1'b0, dividendHigh};
                    q_d       = dividendLow;
                    cnt_d     = CNT_START;
                    if (inputOverflow) begin
                        quot_d     = '1;
                        rem_d      = '0;
                        overflow_d = 1'b1;
                        div_zero_d = (datab == '0);
                    end
                end
            end
            RUN: begin
                r_d = rStep;
                q_d = qStep;
                if (cnt_q == '0) begin
                    quot_d     = qStep;
                    rem_d      = rStep[WIDTH-1:0];
                    overflow_d = 1'b0;
                    div_zero_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            divisor_q  <= '0;
            r_q        <= '0;
            q_q        <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            r_q        <= r_d;
            q_q        <= q_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
            overflow_q <= overflow_d;
        end
    end

    // Handshake outputs decoded from state; results straight from registers
    always_comb begin
        busy     = (state_q != IDLE);
        ready    = (state_q == DONE);
        quot     = quot_q;
        rem      = rem_q;
        div_zero = div_zero_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_p_divider.sv
// tb_p_divider: directed and randomized bench for p_divider (WIDTH=8),
// expected results from plain integer division.
module tb_p_divider;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] dataa;
    logic [7:0]  datab;
    logic        busy;
    logic        ready;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        div_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] holdQuot = 8'h00;
    logic [7:0] holdRem  = 8'h00;

    p_divider #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .dataa    (dataa),
        .datab    (datab),
        .busy     (busy),
        .ready    (ready),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observation against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference division from plain integer arithmetic
    function automatic void refModel(input logic [15:0] a, input logic [7:0] b,
                                     output logic [7:0] q, output logic [7:0] r,
                                     output logic ovf, output logic dz);
        int unsigned ua;
        int unsigned ub;
        int unsigned fullQ;
        ua  = int'(a);
        ub  = int'(b);
        dz  = (ub == 0);
        ovf = dz;
        q   = 8'hFF;
        r   = 8'h00;
        if (!dz) begin
            fullQ = ua / ub;
            if (fullQ > 255) begin
                ovf = 1'b1;
            end else begin
                q = 8'(fullQ);
                r = 8'(ua % ub);
            end
        end
    endfunction

    // Run one complete operation from IDLE and check latency, handshake and results
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
        logic [7:0] eq;
        logic [7:0] er;
        logic       eo;
        logic       ez;
        int         expLat;
        int         edges;
        refModel(a, b, eq, er, eo, ez);
        expLat = eo ? 1 : 9;
        dataa  = a;
        datab  = b;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        dataa  = 16'($urandom);
        datab  = 8'($urandom);
        edges  = 1;
        while (ready !== 1'b1 && edges < 20) begin
            checkOutput("busyRun", 32'(busy), 32'd1);
            checkOutput("quotHold", 32'(quot), 32'(holdQuot));
            checkOutput("remHold", 32'(rem), 32'(holdRem));
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("latency", 32'(edges), 32'(expLat));
        checkOutput("readyHigh", 32'(ready), 32'd1);
        checkOutput("busyDone", 32'(busy), 32'd1);
        checkOutput("quot", 32'(quot), 32'(eq));
        checkOutput("rem", 32'(rem), 32'(er));
        checkOutput("overflow", 32'(overflow), 32'(eo));
        checkOutput("divZero", 32'(div_zero), 32'(ez));
        holdQuot = eq;
        holdRem  = er;
        @(posedge clk); #1;
        checkOutput("readyPulse", 32'(ready), 32'd0);
        checkOutput("busyIdle", 32'(busy), 32'd0);
        checkOutput("quotKeep", 32'(quot), 32'(eq));
    endtask

    // Directed sequence followed by randomized operations
    initial begin
        int n;
        int firstAt;
        int secondAt;
        int pulses;
        logic [7:0] rb;
        logic [7:0] rh;
        logic [7:0] rl;

        reset  = 1'b1;
        enable = 1'b0;
        dataa  = 16'h0000;
        datab  = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstReady", 32'(ready), 32'd0);
        checkOutput("rstQuot", 32'(quot), 32'd0);
        checkOutput("rstRem", 32'(rem), 32'd0);
        checkOutput("rstOvf", 32'(overflow), 32'd0);
        checkOutput("rstDz", 32'(div_zero), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed operations");
        applyStimulus(16'h03E8, 8'h07);
        applyStimulus(16'h7FFF, 8'hFF);
        applyStimulus(16'hFFFF, 8'hFF);
        applyStimulus(16'h1234, 8'h00);

        $display("[TB] enable held through a busy operation");
        dataa  = 16'h03E8;
        datab  = 8'h07;
        enable = 1'b1;
        @(posedge clk); #1;
        dataa    = 16'h0064;
        datab    = 8'h0A;
        n        = 1;
        firstAt  = -1;
        secondAt = -1;
        pulses   = 0;
        while (secondAt < 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ready === 1'b1) begin
                pulses++;
                if (firstAt < 0) begin
                    firstAt = n;
                    checkOutput("b2bQuot1", 32'(quot), 32'd142);
                    checkOutput("b2bRem1", 32'(rem), 32'd6);
                end else begin
                    secondAt = n;
                    checkOutput("b2bQuot2", 32'(quot), 32'h0A);
                    checkOutput("b2bRem2", 32'(rem), 32'h00);
                end
            end
        end
        enable = 1'b0;
        checkOutput("b2bFirstAt", 32'(firstAt), 32'd9);
        checkOutput("b2bSecondAt", 32'(secondAt), 32'd19);
        checkOutput("b2bPulses", 32'(pulses), 32'd2);
        holdQuot = 8'h0A;
        holdRem  = 8'h00;
        @(posedge clk); #1;
        checkOutput("b2bIdle", 32'(busy), 32'd0);

        $display("[TB] asynchronous reset mid-operation");
        dataa  = 16'h03E8;
        datab  = 8'h07;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("midBusy", 32'(busy), 32'd1);
        checkOutput("midQuotHold", 32'(quot), 32'h0A);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arstBusy", 32'(busy), 32'd0);
        checkOutput("arstReady", 32'(ready), 32'd0);
        checkOutput("arstQuot", 32'(quot), 32'd0);
        checkOutput("arstRem", 32'(rem), 32'd0);
        checkOutput("arstOvf", 32'(overflow), 32'd0);
        checkOutput("arstDz", 32'(div_zero), 32'd0);
        @(posedge clk); #1;
        checkOutput("arstNoReady", 32'(ready), 32'd0);
        reset    = 1'b0;
        holdQuot = 8'h00;
        holdRem  = 8'h00;
        @(posedge clk); #1;
        checkOutput("arstStillIdle", 32'(busy), 32'd0);
        applyStimulus(16'h03E8, 8'h07);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                rb = 8'($urandom_range(1, 255));
                rh = 8'($urandom_range(0, int'(rb) - 1));
                rl = 8'($urandom);
                applyStimulus({rh, rl}, rb);
            end else begin
                applyStimulus(16'($urandom), 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
